// File: rtl/vid_htim.sv
// Horizontal video timing generator: free-running line counter with blank/sync
// set/clear flops, driven by a host-written shadow bank copied to an active bank at wrap.
module vid_htim (
   input  logic       vclk,
   input  logic       resetl,
   input  logic       en,
   input  logic       wr,
   input  logic [2:0] addr,
   input  logic [9:0] din,
   output logic [9:0] hc,
   output logic       hblank,
   output logic       hsync,
   output logic       line_end
);

   // Bank index: 0=HP, 1=HBB, 2=HBE, 3=HS, 4=HSE
   localparam logic [4:0][9:0] RST_VAL = {10'd752, 10'd656, 10'd0, 10'd640, 10'd799};

   logic [4:0][9:0] r_sh;
   logic [4:0][9:0] r_act;
   logic [9:0]      r_hc;
   logic            r_hblank;
   logic            r_hsync;
   logic            r_line_end;

   logic            w_at_end;
   logic            w_wrap;

   assign w_at_end = (r_hc == r_act[0]);
   // >= guards against hc ever sitting beyond the period
   assign w_wrap   = en && (r_hc >= r_act[0]);

   always_ff @(posedge vclk or negedge resetl) begin
      if (!resetl) begin
         r_sh  <= RST_VAL;
         r_act <= RST_VAL;
      end else begin
         if (w_wrap)
            r_act <= r_sh;
         for (int i = 0; i < 5; i++) begin
            if (wr && (addr == i[2:0]))
               r_sh[i] <= din;
         end
      end
   end

   always_ff @(posedge vclk or negedge resetl) begin
      if (!resetl) begin
         r_hc       <= 10'd0;
         r_hblank   <= 1'b1;
         r_hsync    <= 1'b0;
         r_line_end <= 1'b0;
      end else begin
         r_line_end <= en && w_at_end;
         if (en) begin
            r_hc <= w_wrap ? 10'd0 : r_hc + 10'd1;
            if (r_hc == r_act[2])
               r_hblank <= 1'b0;
            else if (r_hc == r_act[1])
               r_hblank <= 1'b1;
            if (r_hc == r_act[4])
               r_hsync <= 1'b0;
            else if (r_hc == r_act[3])
               r_hsync <= 1'b1;
         end
      end
   end

   assign hc       = r_hc;
   assign hblank   = r_hblank;
   assign hsync    = r_hsync;
   assign line_end = r_line_end;

endmodule

// File: tb/tb_vid_htim.sv
// Bench for vid_htim: per-cycle reference model feeding a scoreboard queue,
// plus directed period / hold / reset scenarios.
module tb_vid_htim;
   logic       vclk = 1'b0;
   logic       resetl = 1'b0;
   logic       en = 1'b0;
   logic       wr = 1'b0;
   logic [2:0] addr = 3'd0;
   logic [9:0] din = 10'd0;
   logic [9:0] hc;
   logic       hblank;
   logic       hsync;
   logic       line_end;

   vid_htim dut (
      .vclk(vclk), .resetl(resetl), .en(en), .wr(wr), .addr(addr), .din(din),
      .hc(hc), .hblank(hblank), .hsync(hsync), .line_end(line_end)
   );

   always #5 vclk = ~vclk;

   typedef struct {
      logic [9:0] hc;
      logic       hb;
      logic       hs;
      logic       le;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         hs_cnt = 0;
   int         hb_cnt = 0;

   logic [9:0] m_hc;
   logic       m_hb, m_hs, m_le;
   logic [9:0] m_sh[5];
   logic [9:0] m_act[5];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_hc = 10'd0; m_hb = 1'b1; m_hs = 1'b0; m_le = 1'b0;
      m_sh[0] = 10'd799; m_sh[1] = 10'd640; m_sh[2] = 10'd0;
      m_sh[3] = 10'd656; m_sh[4] = 10'd752;
      for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
   endtask

   task automatic do_reset();
      @(negedge vclk);
      resetl = 1'b0; en = 1'b0; wr = 1'b0;
      #1;
      chk("rst_hc", hc, 0);
      chk("rst_hblank", hblank, 1);
      chk("rst_hsync", hsync, 0);
      chk("rst_line_end", line_end, 0);
      sb_q.delete();
      model_reset();
      @(negedge vclk);
      resetl = 1'b1;
   endtask

   // One clock: drive inputs, predict outputs, compare after the edge
   task automatic step(input logic e, input logic w, input logic [2:0] a, input logic [9:0] d);
      exp_t x;
      logic wrap;
      @(negedge vclk);
      en = e; wr = w; addr = a; din = d;
      if (e) begin
         wrap = (m_hc >= m_act[0]);
         m_le = (m_hc == m_act[0]);
         if (m_hc == m_act[2]) m_hb = 1'b0;
         else if (m_hc == m_act[1]) m_hb = 1'b1;
         if (m_hc == m_act[4]) m_hs = 1'b0;
         else if (m_hc == m_act[3]) m_hs = 1'b1;
         m_hc = wrap ? 10'd0 : m_hc + 10'd1;
         if (wrap) for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      end else begin
         m_le = 1'b0;
      end
      if (w && (a < 3'd5)) m_sh[int'(a)] = d;
      x.hc = m_hc; x.hb = m_hb; x.hs = m_hs; x.le = m_le;
      sb_q.push_back(x);
      @(posedge vclk);
      #1;
      x = sb_q.pop_front();
      chk("sb_hc", hc, x.hc);
      chk("sb_hblank", hblank, x.hb);
      chk("sb_hsync", hsync, x.hs);
      chk("sb_line_end", line_end, x.le);
      if (hsync === 1'b1) hs_cnt++;
      if (hblank === 1'b1) hb_cnt++;
      en = 1'b0; wr = 1'b0;
   endtask

   task automatic wait_le(output int n);
      n = 0;
      do begin
         step(1'b1, 1'b0, 3'd0, 10'd0);
         n++;
      end while (line_end !== 1'b1 && n < 2000);
      if (line_end !== 1'b1) chk("le_timeout", 0, 1);
   endtask

   task automatic run_to(input logic [9:0] t);
      int g;
      g = 0;
      while (m_hc != t && g < 2000) begin
         step(1'b1, 1'b0, 3'd0, 10'd0);
         g++;
      end
      chk("run_to", hc, t);
   endtask

   initial begin
      int n;
      model_reset();

      // Default 800-cycle line, blank/sync widths
      do_reset();
      wait_le(n); chk("per_first", n, 800);
      hs_cnt = 0; hb_cnt = 0;
      wait_le(n); chk("per_second", n, 800);
      chk("hsync_width", hs_cnt, 96);
      chk("hblank_width", hb_cnt, 160);

      // HP=9 written mid-line takes effect after the next wrap
      run_to(10'd100);
      step(1'b1, 1'b1, 3'd0, 10'd9);
      wait_le(n); chk("hp9_cur_line", n, 699);
      wait_le(n); chk("hp9_per1", n, 10);
      wait_le(n); chk("hp9_per2", n, 10);

      // Write on the exact wrap edge reaches active one line later
      do_reset();
      run_to(10'd799);
      step(1'b1, 1'b1, 3'd0, 10'd4);
      chk("wrapwr_le", line_end, 1);
      wait_le(n); chk("wrapwr_per800", n, 800);
      wait_le(n); chk("wrapwr_per5a", n, 5);
      wait_le(n); chk("wrapwr_per5b", n, 5);

      // Equal set/clear positions: clear wins
      step(1'b1, 1'b1, 3'd3, 10'd5);
      step(1'b1, 1'b1, 3'd4, 10'd5);
      step(1'b1, 1'b1, 3'd1, 10'd3);
      step(1'b1, 1'b1, 3'd2, 10'd3);
      step(1'b1, 1'b1, 3'd0, 10'd9);
      wait_le(n);
      wait_le(n);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 3'd0, 10'd0);
         chk("eq_hsync", hsync, 0);
         chk("eq_hblank", hblank, 0);
      end
      chk("eq_hc", hc, 0);

      // en low holds state; addr 6 write is ignored
      do_reset();
      run_to(10'd300);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, (i == 3), 3'd6, 10'h3FF);
         chk("hold_hc", hc, 300);
         chk("hold_le", line_end, 0);
      end
      step(1'b1, 1'b0, 3'd0, 10'd0);
      chk("resume_hc", hc, 301);
      wait_le(n); chk("resume_rest", n, 499);
      wait_le(n); chk("addr6_per", n, 800);

      // Asynchronous reset mid-sync
      run_to(10'd700);
      chk("pre_rst_hsync", hsync, 1);
      do_reset();
      wait_le(n); chk("post_rst_per", n, 800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
